data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_pkg.sv | 51 +++++
 rtl/sync_fifo.sv | 58 +++++
 rtl/data_mem.sv | 144 ++++++++++++++
 tb/tb_data_mem.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory: access sizes, response
// record, storage pipeline stage record and lane/extension functions.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } rsp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        error;
        logic [1:0]  size;
        logic [1:0]  lane;
        logic        is_unsigned;
    } stage_t;

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << lane;
            SIZE_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Half-word lanes are always 0 or 2, so one shift serves byte and half.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic is_unsigned);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: result = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            SIZE_HALF: result = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            SIZE_WORD: result = word;
            default:   result = 32'h0000_0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on
// dout whenever valid is high.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign dout    = mem[rd_ptr];
    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with byte/half/word access, a fixed-latency
// read pipeline and an in-order response FIFO sized by the credit counter.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error
);
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int SLOTS  = READ_LATENCY + 2;
    localparam int OUT_W  = $clog2(SLOTS + 1);

    logic [31:0]       mem [DEPTH_WORDS];
    stage_t            pipe [READ_LATENCY];
    logic [OUT_W-1:0]  outstanding;
    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic [1:0]        lane;
    logic              req_err;
    logic              accept;
    logic              xfer;
    logic [3:0]        wmask;
    logic [31:0]       wdata_rep;
    stage_t            stage_in;
    rsp_t              fifo_in;
    rsp_t              fifo_out;
    logic              fifo_valid;
    logic              fifo_full;

    assign word_idx  = req_addr[ADDR_WIDTH-1:2];
    assign mem_idx   = word_idx[MEM_AW-1:0];
    assign lane      = req_addr[1:0];
    assign req_ready = !rst && (outstanding < OUT_W'(SLOTS));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = fifo_valid && !rst;
    assign xfer      = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? fifo_out.rdata : 32'h0000_0000;
    assign rsp_error = rsp_valid && fifo_out.error;
    assign wmask     = store_mask(req_size, lane);

    // Fault decode: illegal size, misalignment, or word beyond the array.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = lane[0];
            SIZE_WORD: req_err = (lane != 2'b00);
            default:   req_err = 1'b1;
        endcase
        if (64'(word_idx) >= 64'(DEPTH_WORDS)) begin
            req_err = 1'b1;
        end else begin
            req_err = req_err;
        end
    end

    // Replicate store data across lanes so the byte mask alone selects.
    always_comb begin
        wdata_rep = req_wdata;
        case (req_size)
            SIZE_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SIZE_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default:   wdata_rep = req_wdata;
        endcase
    end

    // Store commit at the acceptance edge; faulted requests never write.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // Stage 0 contents; stores and faults carry zero data.
    always_comb begin
        stage_in.valid       = accept;
        stage_in.data        = (!req_write && !req_err) ? mem[mem_idx] : 32'h0000_0000;
        stage_in.error       = req_err;
        stage_in.size        = req_size;
        stage_in.lane        = lane;
        stage_in.is_unsigned = req_unsigned;
    end

    // Fixed-latency storage pipeline; never stalls because credits bound it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign fifo_in.rdata = pipe[READ_LATENCY-1].error ? 32'h0000_0000 :
                           load_extend(pipe[READ_LATENCY-1].data, pipe[READ_LATENCY-1].size,
                                       pipe[READ_LATENCY-1].lane, pipe[READ_LATENCY-1].is_unsigned);
    assign fifo_in.error = pipe[READ_LATENCY-1].error;

    // Credit counter: requests accepted but whose response is not yet taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, xfer})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH($bits(rsp_t)),
        .DEPTH(SLOTS)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe[READ_LATENCY-1].valid),
        .din   (fifo_in),
        .pop   (xfer),
        .dout  (fifo_out),
        .valid (fifo_valid),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: instance 0 uses READ_LATENCY=1, instance 1
// uses READ_LATENCY=3; both have a 64-word array.
module tb_data_mem;
    import data_mem_pkg::*;

    logic             clk = 1'b0;
    logic [1:0]       rst;
    logic [1:0]       req_valid, req_ready, req_write, req_unsigned;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]       rsp_valid, rsp_ready, rsp_error;

    logic [32:0] exp_q [2][$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem #(.ADDR_WIDTH(32), .DEPTH_WORDS(64), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]));

    data_mem #(.ADDR_WIDTH(32), .DEPTH_WORDS(64), .READ_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]));

    // Scoreboard: every transferred response must match the oldest expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rsp_valid[k] && rsp_ready[k]) begin
                checks++;
                if (exp_q[k].size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected dut=%0d got rdata=%h err=%b, none expected",
                             k, rsp_rdata[k], rsp_error[k]);
                end else if ({rsp_rdata[k], rsp_error[k]} !== exp_q[k][0]) begin
                    failures++;
                    $display("FAIL rsp_data dut=%0d got rdata=%h err=%b want rdata=%h err=%b",
                             k, rsp_rdata[k], rsp_error[k], exp_q[k][0][32:1], exp_q[k][0][0]);
                    void'(exp_q[k].pop_front());
                end else begin
                    void'(exp_q[k].pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] bval(input int i);
        return 32'hA500_0000 | (i * 32'h0001_0203);
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic issue(input int k, input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e);
        int budget;
        budget = 0;
        req_valid[k] = 1'b1; req_write[k] = w; req_size[k] = sz;
        req_unsigned[k] = uns; req_addr[k] = addr; req_wdata[k] = wd;
        @(negedge clk);
        while (!req_ready[k] && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready[k]) begin
            checks++; failures++;
            $display("FAIL accept_timeout dut=%0d addr=%h ready=%b want 1", k, addr, req_ready[k]);
            req_valid[k] = 1'b0;
            sync();
        end else begin
            exp_q[k].push_back({exp_d, exp_e});
            sync();
            req_valid[k] = 1'b0;
        end
    endtask

    task automatic wait_drain(input int k);
        int budget;
        budget = 0;
        while (exp_q[k].size() != 0 && budget < 200) begin
            sync();
            budget++;
        end
        checks++;
        if (exp_q[k].size() != 0) begin
            failures++;
            $display("FAIL drain_timeout dut=%0d pending=%0d want 0", k, exp_q[k].size());
        end
        sync();
    endtask

    task automatic test_reset();
        rst = 2'b11; rsp_ready = 2'b11; req_valid = 2'b00; req_write = 2'b00;
        req_unsigned = 2'b00; req_size = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_error[k]} !== 35'h0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got ready=%b valid=%b rdata=%h err=%b want all 0",
                         k, req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_error[k]);
            end
        end
        sync();
        rst = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1) begin
                failures++;
                $display("FAIL ready_after_reset dut=%0d got %b want 1", k, req_ready[k]);
            end
        end
        sync();
    endtask

    task automatic test_store_load();
        issue(0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue(0, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        wait_drain(0);
    endtask

    task automatic test_latency();
        issue(0, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL latency_early got rsp_valid=%b in N+1 want 0", rsp_valid[0]);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL latency_n2 got valid=%b rdata=%h want 1 deadbeef", rsp_valid[0], rsp_rdata[0]);
        end
        sync();
        wait_drain(0);
    endtask

    task automatic test_extend();
        issue(0, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0);
        issue(0, 1'b0, SIZE_BYTE, 1'b0, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0);
        issue(0, 1'b0, SIZE_BYTE, 1'b1, 32'h23, 32'h0, 32'h0000_0080, 1'b0);
        issue(0, 1'b0, SIZE_HALF, 1'b0, 32'h20, 32'h0, 32'h0000_7F01, 1'b0);
        issue(0, 1'b0, SIZE_HALF, 1'b1, 32'h22, 32'h0, 32'h0000_80FF, 1'b0);
        issue(0, 1'b0, SIZE_HALF, 1'b0, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0);
        issue(0, 1'b0, SIZE_BYTE, 1'b0, 32'h21, 32'h0, 32'h0000_007F, 1'b0);
        wait_drain(0);
    endtask

    task automatic test_partial_store();
        issue(0, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        issue(0, 1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'hFFFF_FFAA, 32'h0, 1'b0);
        issue(0, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, 32'h1122_AA44, 1'b0);
        issue(0, 1'b1, SIZE_HALF, 1'b0, 32'h22, 32'h1234_BEEF, 32'h0, 1'b0);
        issue(0, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, 32'hBEEF_AA44, 1'b0);
        wait_drain(0);
    endtask

    task automatic test_errors();
        issue(0, 1'b1, SIZE_WORD, 1'b0, 32'h00, 32'h0102_0304, 32'h0, 1'b0);
        issue(0, 1'b0, SIZE_HALF, 1'b0, 32'h01, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b0, SIZE_WORD, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b0, 2'b11,     1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b1, SIZE_WORD, 1'b0, 32'h100, 32'h5555_5555, 32'h0, 1'b1);
        issue(0, 1'b1, SIZE_HALF, 1'b0, 32'h21, 32'h0000_6666, 32'h0, 1'b1);
        issue(0, 1'b1, 2'b11,     1'b0, 32'h20, 32'h7777_7777, 32'h0, 1'b1);
        issue(0, 1'b0, SIZE_WORD, 1'b0, 32'h00, 32'h0, 32'h0102_0304, 1'b0);
        issue(0, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, 32'hBEEF_AA44, 1'b0);
        wait_drain(0);
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) issue(0, 1'b1, SIZE_WORD, 1'b0, 32'h80 + 4*i, bval(i), 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) issue(0, 1'b0, SIZE_WORD, 1'b0, 32'h80 + 4*i, 32'h0, bval(i), 1'b0);
        checks++;
        if (cyc - t0 != 16) begin
            failures++;
            $display("FAIL b2b_throughput got %0d cycles want 16", cyc - t0);
        end
        wait_drain(0);
    endtask

    task automatic test_backpressure();
        int t_first, budget;
        for (int i = 0; i < 8; i++) issue(1, 1'b1, SIZE_WORD, 1'b0, 32'h40 + 4*i, bval(i), 32'h0, 1'b0);
        wait_drain(1);
        rsp_ready[1] = 1'b0;
        for (int i = 0; i < 5; i++) issue(1, 1'b0, SIZE_WORD, 1'b0, 32'h40 + 4*i, 32'h0, bval(i), 1'b0);
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL ready_full got %b want 0 after 5 accepts", req_ready[1]);
        end
        budget = 0;
        while (!rsp_valid[1] && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== bval(0) || rsp_error[1] !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable got valid=%b rdata=%h err=%b want 1 %h 0",
                         rsp_valid[1], rsp_rdata[1], rsp_error[1], bval(0));
            end
        end
        sync();
        rsp_ready[1] = 1'b1;
        issue(1, 1'b0, SIZE_WORD, 1'b0, 32'h54, 32'h0, bval(5), 1'b0);
        t_first = cyc;
        for (int i = 6; i < 13; i++) issue(1, 1'b0, SIZE_WORD, 1'b0, 32'h40 + 4*(i % 8), 32'h0, bval(i % 8), 1'b0);
        checks++;
        if (cyc - t_first != 7) begin
            failures++;
            $display("FAIL bp_throughput got %0d cycles want 7", cyc - t_first);
        end
        wait_drain(1);
    endtask

    task automatic test_reset_mid();
        rsp_ready[1] = 1'b0;
        issue(1, 1'b1, SIZE_WORD, 1'b0, 32'h60, 32'hCAFE_F00D, 32'h0, 1'b0);
        issue(1, 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, bval(0), 1'b0);
        issue(1, 1'b0, SIZE_WORD, 1'b0, 32'h44, 32'h0, bval(1), 1'b0);
        repeat (5) sync();
        rst[1] = 1'b1;
        exp_q[1].delete();
        @(negedge clk);
        sync();
        @(negedge clk);
        checks++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got valid=%b ready=%b want 0 0", rsp_valid[1], req_ready[1]);
        end
        sync();
        rst[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL stale_after_reset got valid=%b rdata=%h want 0", rsp_valid[1], rsp_rdata[1]);
        end
        sync();
        rsp_ready[1] = 1'b1;
        issue(1, 1'b0, SIZE_WORD, 1'b0, 32'h60, 32'h0, 32'hCAFE_F00D, 1'b0);
        issue(1, 1'b0, SIZE_WORD, 1'b0, 32'h48, 32'h0, bval(2), 1'b0);
        wait_drain(1);
        repeat (4) sync();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_latency();
        test_extend();
        test_partial_store();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        wait_drain(0);
        wait_drain(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
